// File: rtl/vga_face_pkg.sv
// Shared face encoding and frame geometry for the face streamer and its scheduler.
package vga_face_pkg;

  localparam int unsigned NUM_FACES  = 3;
  localparam int unsigned VGA_WIDTH  = 640;
  localparam int unsigned VGA_HEIGHT = 480;
  localparam int unsigned NumPixels  = VGA_WIDTH * VGA_HEIGHT;

  typedef enum logic [1:0] {
    Wolf  = 2'd0,
    P2    = 2'd1,
    Troll = 2'd2
  } face_t;

  typedef enum logic {
    StShowDefault,
    StShowReq
  } sched_state_t;

  // Code 3 has no ROM behind it, so it falls back to Wolf.
  function automatic face_t sanitize_face(input logic [1:0] f);
    return (f == 2'd3) ? Wolf : face_t'(f);
  endfunction

endpackage

// File: rtl/face_scheduler_if.sv
// Request/monitor/select bundle between the requesters, the streamer and face_scheduler.
interface face_scheduler_if #(
  parameter int unsigned CNT_W = 8
);

  logic [2:0]       req;
  logic [1:0]       default_face;
  logic             st_valid;
  logic             st_ready;
  logic             st_endofpacket;
  logic [1:0]       face_select;
  logic             showing_request;
  logic [2:0]       pending;
  logic [CNT_W-1:0] frames_left;
  logic             switch_pulse;

  modport master (
    output req, default_face, st_valid, st_ready, st_endofpacket,
    input  face_select, showing_request, pending, frames_left, switch_pulse
  );

  modport slave (
    input  req, default_face, st_valid, st_ready, st_endofpacket,
    output face_select, showing_request, pending, frames_left, switch_pulse
  );

endinterface

// File: rtl/face_rr_arbiter.sv
// Three-way combinational round-robin: the index after i_rr_last has top priority.
module face_rr_arbiter
  import vga_face_pkg::*;
(
  input  logic [2:0] i_pending,
  input  logic [1:0] i_rr_last,
  output logic       o_grant_valid,
  output logic [1:0] o_grant_idx
);

  logic [1:0] w_cand;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    o_grant_valid = 1'b0;
    o_grant_idx   = 2'd0;
    w_cand        = 2'd0;
    for (int k = int'(NUM_FACES) - 1; k >= 0; k--) begin
      w_cand = 2'((int'(i_rr_last) + 1 + k) % int'(NUM_FACES));
      if (i_pending[w_cand]) begin
        o_grant_valid = 1'b1;
        o_grant_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/face_scheduler.sv
// Frame-synchronous face selector: sticky requests, round-robin grants, minimum hold, default.
module face_scheduler
  import vga_face_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  face_scheduler_if.slave  bus
);

  sched_state_t     r_state, w_state_d;
  face_t            r_face, w_face_d;
  logic [CNT_W-1:0] r_frames_left, w_frames_left_d;
  logic [1:0]       r_rr_last, w_rr_last_d;
  logic [2:0]       r_pending, w_pending_d, w_clr;
  logic             r_switch_pulse;
  logic             w_eof_fire;
  logic             w_grant_valid;
  logic [1:0]       w_grant_idx;

  assign w_eof_fire = bus.st_valid & bus.st_ready & bus.st_endofpacket;

  face_rr_arbiter u_arb (
    .i_pending     (r_pending),
    .i_rr_last     (r_rr_last),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_d       = r_state;
    w_face_d        = r_face;
    w_frames_left_d = r_frames_left;
    w_rr_last_d     = r_rr_last;
    w_clr           = 3'b000;
    if (w_eof_fire) begin
      case (r_state)
        StShowDefault: begin
          if (w_grant_valid) begin
            w_state_d       = StShowReq;
            w_face_d        = face_t'(w_grant_idx);
            w_frames_left_d = CNT_W'(HOLD_FRAMES - 1);
            w_rr_last_d     = w_grant_idx;
            w_clr[w_grant_idx] = 1'b1;
          end else begin
            w_face_d = sanitize_face(bus.default_face);
          end
        end
        StShowReq: begin
          if (r_frames_left != '0) begin
            w_frames_left_d = r_frames_left - 1'b1;
          end else if (w_grant_valid) begin
            w_face_d        = face_t'(w_grant_idx);
            w_frames_left_d = CNT_W'(HOLD_FRAMES - 1);
            w_rr_last_d     = w_grant_idx;
            w_clr[w_grant_idx] = 1'b1;
          end else begin
            w_state_d = StShowDefault;
            w_face_d  = sanitize_face(bus.default_face);
          end
        end
        default: w_state_d = StShowDefault;
      endcase
    end
    // A request landing on the grant cycle must survive the clear.
    w_pending_d = (r_pending & ~w_clr) | bus.req;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StShowDefault;
      r_face         <= Wolf;
      r_frames_left  <= '0;
      r_rr_last      <= 2'd2;
      r_pending      <= 3'b000;
      r_switch_pulse <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_face         <= w_face_d;
      r_frames_left  <= w_frames_left_d;
      r_rr_last      <= w_rr_last_d;
      r_pending      <= w_pending_d;
      r_switch_pulse <= (w_face_d != r_face);
    end
  end

  assign bus.face_select     = r_face;
  assign bus.showing_request = (r_state == StShowReq);
  assign bus.pending         = r_pending;
  assign bus.frames_left     = r_frames_left;
  assign bus.switch_pulse    = r_switch_pulse;

endmodule

// File: doc/face_scheduler.md
Name: face_scheduler

Overview:
- Sequences the `face_select` input of the 640x480 face streamer (Avalon-ST, 30-bit RGB) between competing requesters, e.g. game events or audio triggers.
- Requests are latched as sticky pending bits and arbitrated round-robin.
- A face change happens only on a frame boundary, so every frame is drawn from a single face.
- A granted face is held for a minimum number of frames, then the block falls back to a configurable default face.

Parameters:
- HOLD_FRAMES, 60, number of complete frames a granted face stays on screen; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the hold counter and of `frames_left`.
- NUM_FACES, 3, number of requesters/faces; fixed at 3 in this revision.

Ports:
- clk  in  1  system clock; the same clock as the face streamer.
- reset  in  1  synchronous, active-high reset.
- req  in  3  one-cycle request pulses, indexed by face code: bit0 Wolf, bit1 P2, bit2 Troll.
- default_face  in  2  face shown when no request is active; sampled only at frame boundaries.
- st_valid  in  1  monitored `valid` of the streamer output.
- st_ready  in  1  monitored `ready` of the sink.
- st_endofpacket  in  1  monitored `endofpacket` of the streamer.
- face_select  out  2  drives the streamer's `face_select`; encoding Wolf=0, P2=1, Troll=2.
- showing_request  out  1  high while a granted face is being held.
- pending  out  3  current sticky request bits.
- frames_left  out  CNT_W  remaining hold frames after the current one.
- switch_pulse  out  1  one-cycle pulse in the cycle after `face_select` changes value.

Behaviour:
- Frame-boundary event: eof_fire = st_valid & st_ready & st_endofpacket.
  - All selection changes are registered on the eof_fire clock edge.
  - The streamer muxes its ROM outputs with `face_select` combinationally, so the new face covers pixel 0 of the next frame onward.
- Reset values (synchronous, applied on any cycle, including mid-frame):
  - face_select=0 (Wolf), state=SHOW_DEFAULT, pending=0, frames_left=0.
  - rr_last=2, so face 0 has top priority first.
  - switch_pulse=0, showing_request=0.
- Pending bits:
  - pending[i] is set by req[i].
  - pending[i] is cleared when face i is granted.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the request stays pending.
  - Requests arriving during reset are dropped.
- Arbitration: round-robin. Search order is (rr_last+1)%3, (rr_last+2)%3, rr_last. rr_last updates to the granted index.
- Default face sanitising: default_face=3 is treated as Wolf (0).
- State SHOW_DEFAULT, on eof_fire:
  - If pending≠0: grant, face_select<=grant, frames_left<=HOLD_FRAMES-1, go to SHOW_REQ.
  - Else: face_select<=sanitised default_face and stay.
- State SHOW_REQ, on eof_fire:
  - If frames_left≠0: decrement and stay.
  - Else if pending≠0: grant the next face and reload frames_left.
  - Else: face_select<=sanitised default_face, go to SHOW_DEFAULT.
- No eof_fire: face_select, state and frames_left hold. A stalled stream (ready=0) therefore freezes the schedule.
- A re-grant of the same face still reloads the hold. switch_pulse fires only when the value actually changes.
- showing_request = (state==SHOW_REQ).
- Latency:
  - A request to a visible face change takes at least until the next eof_fire, plus any remaining hold frames.
  - With HOLD_FRAMES=1, each grant lasts exactly one frame.

Decomposition:
- Package `vga_face_pkg`:
  - `face_t` enum (Wolf=0, P2=1, Troll=2).
  - NUM_FACES, VGA_WIDTH/HEIGHT, NumPixels.
  - A `sanitize_face` function.
  - The streamer adopts the same enum.
- Sub-module `face_rr_arbiter`: 3-way combinational round-robin taking pending and rr_last, producing grant_valid and grant_idx. The FSM, counter and pending registers stay in `face_scheduler`.

Test Plan:
- Reset, then eof_fire with no req and default_face=2 -> face_select=2 after that edge, switch_pulse high for 1 cycle, showing_request=0.
- HOLD_FRAMES=3; req[1] pulse mid-frame -> face_select stays at default until eof_fire, then 1. It holds for 3 frames (frames_left 2,1,0) and returns to default at the 4th eof_fire.
- req=3'b111 in one cycle after reset, HOLD_FRAMES=1 -> grants in order 0,1,2 on successive eof_fires, pending 111→110→100→000, then default.
- st_ready=0 while st_endofpacket=1 and st_valid=1 for 5 cycles -> no state change; the change occurs in the cycle after ready rises.
- req[0] asserted in the same cycle face 0 is granted -> pending[0] stays 1, and face 0 is re-granted after the hold (switch_pulse=0 on the re-grant).
- Reset asserted mid-hold with face_select=2, frames_left=5 -> next cycle face_select=0, pending=0, frames_left=0, SHOW_DEFAULT.
- default_face=3 with no pending -> face_select=0 at eof_fire.
